// File: rtl/sevenseg_pkg.sv
// sevenseg_pkg: segment bit positions and the hex-to-segment pattern table
package sevenseg_pkg;
  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;
  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };
endpackage

// File: rtl/hex_to_seg.sv
// hex_to_seg: combinational nibble to seven-segment pattern lookup
module hex_to_seg
  import sevenseg_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);
  // table lookup; every nibble value has an entry
  always_comb seg = HEX_SEG[nib];
endmodule

// File: rtl/sevenseg_scan.sv
// sevenseg_scan: double-buffered multiplexed seven-segment scanner with ghost gap and leading-zero blanking
module sevenseg_scan
  import sevenseg_pkg::*;
#(
  parameter int NDIGITS = 4,
  parameter int DIV     = 1000,
  parameter int BLANK   = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load,
  input  logic [4*NDIGITS-1:0]   value,
  input  logic [NDIGITS-1:0]     dp_in,
  input  logic                   blank_lz,
  output logic [6:0]             segments,
  output logic                   dp,
  output logic [NDIGITS-1:0]     digit_en
);
  localparam int CW = DIV > 1 ? $clog2(DIV) : 1;
  localparam int IW = NDIGITS > 1 ? $clog2(NDIGITS) : 1;
  logic [4*NDIGITS-1:0] shadow_val, disp_val;
  logic [NDIGITS-1:0]   shadow_dp, disp_dp, lz;
  logic                 pending, slot_end, frame_wrap, gap, blanked;
  logic [CW-1:0]        cnt;
  logic [IW-1:0]        idx;
  logic [3:0]           nib;
  logic [6:0]           pat;
  assign slot_end   = cnt == CW'(DIV - 1);
  assign frame_wrap = slot_end && idx == IW'(NDIGITS - 1);
  assign gap        = cnt < CW'(BLANK);
  assign nib        = disp_val[4*idx +: 4];
  assign blanked    = blank_lz && idx != '0 && lz[idx];
  // lz[i]: digit i and everything more significant are zero
  for (genvar i = 0; i < NDIGITS; i++) begin : g_lz
    assign lz[i] = disp_val[4*NDIGITS-1:4*i] == '0;
  end
  hex_to_seg u_dec (.nib(nib), .seg(pat));
  // scan counters, double buffer and registered pin drivers
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      idx        <= '0;
      shadow_val <= '0;
      shadow_dp  <= '0;
      disp_val   <= '0;
      disp_dp    <= '0;
      pending    <= 1'b0;
      segments   <= SEG_BLANK;
      dp         <= 1'b0;
      digit_en   <= '0;
    end else begin
      cnt <= slot_end ? '0 : cnt + 1'b1;
      if (slot_end) idx <= frame_wrap ? '0 : idx + 1'b1;
      if (load) begin
        shadow_val <= value;
        shadow_dp  <= dp_in;
      end
      if (frame_wrap && load) begin
        disp_val <= value;
        disp_dp  <= dp_in;
        pending  <= 1'b0;
      end else if (load) begin
        pending <= 1'b1;
      end else if (frame_wrap && pending) begin
        disp_val <= shadow_val;
        disp_dp  <= shadow_dp;
        pending  <= 1'b0;
      end
      segments <= (gap || blanked) ? SEG_BLANK : pat;
      dp       <= !gap && disp_dp[idx];
      digit_en <= gap ? '0 : NDIGITS'(1) << idx;
    end
  end
endmodule

// File: tb/tb_sevenseg_scan.sv
// tb_sevenseg_scan: table-driven, directed and randomized checks against a cycle-count reference model
module tb_sevenseg_scan;
  localparam int ND = 4;
  localparam int DV = 4;
  localparam int BL = 1;
  localparam int FRAME = ND * DV;
  localparam logic [6:0] PAT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };
  typedef struct {
    logic [15:0]     v;
    logic [3:0]      dpi;
    logic            blz;
    logic [3:0][6:0] segs;
    logic [3:0]      edp;
  } vec_t;
  logic clk = 0, reset = 1, load = 0, blank_lz = 0;
  logic [15:0] value = 0;
  logic [3:0]  dp_in = 0;
  logic [6:0]  segments;
  logic        dp;
  logic [3:0]  digit_en;
  int checks = 0, errors = 0;
  int m_t = 0;
  logic [15:0] m_disp = 0, m_shadow = 0;
  logic [3:0]  m_dp = 0, m_sdp = 0;
  logic        m_pend = 0;
  logic [6:0]  seen_seg [4];
  logic [3:0]  seen_dp;
  bit          saw_a = 0;
  vec_t        tbl [4];

  sevenseg_scan #(.NDIGITS(ND), .DIV(DV), .BLANK(BL)) dut (
    .clk(clk), .reset(reset), .load(load), .value(value), .dp_in(dp_in),
    .blank_lz(blank_lz), .segments(segments), .dp(dp), .digit_en(digit_en)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at t=%0d: got %0h, expected %0h", name, m_t, act, exp);
    end
  endtask

  // one clock: predict outputs from model state, advance the model, then compare
  task automatic step();
    logic [6:0] es;
    logic       ed;
    logic [3:0] ee, nib;
    int         c, ix;
    bit         wrap;
    es = 0; ed = 0; ee = 0;
    if (!reset) begin
      c  = m_t % DV;
      ix = (m_t / DV) % ND;
      if (c >= BL) begin
        nib = 4'((m_disp >> (4 * ix)) & 16'hF);
        es  = (blank_lz && ix > 0 && (m_disp >> (4 * ix)) == 0) ? 7'h00 : PAT[nib];
        ed  = m_dp[ix];
        ee  = 4'(1 << ix);
      end
    end
    if (reset) begin
      m_t = 0; m_disp = 0; m_dp = 0; m_shadow = 0; m_sdp = 0; m_pend = 0;
    end else begin
      wrap = (m_t % FRAME) == FRAME - 1;
      if (load && wrap) begin
        m_disp = value; m_dp = dp_in; m_pend = 0;
      end else if (load) begin
        m_pend = 1;
      end else if (wrap && m_pend) begin
        m_disp = m_shadow; m_dp = m_sdp; m_pend = 0;
      end
      if (load) begin
        m_shadow = value; m_sdp = dp_in;
      end
      m_t++;
    end
    @(posedge clk);
    #1;
    chk("segments", 32'(segments), 32'(es));
    chk("dp", 32'(dp), 32'(ed));
    chk("digit_en", 32'(digit_en), 32'(ee));
    for (int d = 0; d < ND; d++)
      if (digit_en[d]) begin
        seen_seg[d] = segments;
        seen_dp[d]  = dp;
      end
    if (segments == 7'h77) saw_a = 1;
  endtask

  task automatic do_reset(input int n);
    load  = 0;
    reset = 1;
    repeat (n) step();
    reset = 0;
  endtask

  task automatic run_to(input int t);
    while (m_t < t) step();
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    load = 1; value = v; dp_in = d;
    step();
    load = 0;
  endtask

  // observe the whole second frame after reset and compare each digit
  task automatic frame_check(input string tag, input logic [3:0][6:0] es, input logic [3:0] edp);
    run_to(17);
    for (int d = 0; d < ND; d++) seen_seg[d] = 'x;
    seen_dp = 'x;
    run_to(32);
    for (int d = 0; d < ND; d++) chk($sformatf("%s digit%0d segments", tag, d), 32'(seen_seg[d]), 32'(es[d]));
    chk({tag, " dp per digit"}, 32'(seen_dp), 32'(edp));
  endtask

  initial begin
    tbl[0] = '{16'h1234, 4'b0010, 1'b0, {7'h06, 7'h5B, 7'h4F, 7'h66}, 4'b0010};
    tbl[1] = '{16'h0050, 4'b0000, 1'b1, {7'h00, 7'h00, 7'h6D, 7'h3F}, 4'b0000};
    tbl[2] = '{16'h0050, 4'b0000, 1'b0, {7'h3F, 7'h3F, 7'h6D, 7'h3F}, 4'b0000};
    tbl[3] = '{16'h0000, 4'b1111, 1'b1, {7'h00, 7'h00, 7'h00, 7'h3F}, 4'b1111};

    do_reset(3);
    step();
    step();
    chk("first digit_en after reset", 32'(digit_en), 32'h1);
    chk("first segments after reset", 32'(segments), 32'h3F);
    chk("first dp after reset", 32'(dp), 32'h0);

    for (int i = 0; i < 4; i++) begin
      blank_lz = tbl[i].blz;
      do_reset(3);
      run_to(5);
      do_load(tbl[i].v, tbl[i].dpi);
      frame_check($sformatf("vec%0d", i), tbl[i].segs, tbl[i].edp);
    end

    blank_lz = 0;
    saw_a = 0;
    do_reset(2);
    run_to(2);
    do_load(16'hAAAA, 4'b0000);
    run_to(8);
    do_load(16'hBEEF, 4'b0000);
    frame_check("last load wins", {7'h7C, 7'h79, 7'h79, 7'h71}, 4'b0000);
    chk("overwritten value displayed", 32'(saw_a), 32'h0);

    do_reset(2);
    run_to(15);
    do_load(16'hFFFF, 4'b0000);
    chk("pending after wrap bypass", 32'(dut.pending), 32'h0);
    frame_check("wrap bypass", {7'h71, 7'h71, 7'h71, 7'h71}, 4'b0000);

    do_reset(2);
    run_to(2);
    do_load(16'h1234, 4'b1111);
    run_to(9);
    reset = 1;
    step();
    chk("mid-frame reset digit_en", 32'(digit_en), 32'h0);
    chk("mid-frame reset segments", 32'(segments), 32'h0);
    reset = 0;
    step();
    step();
    chk("restart digit_en", 32'(digit_en), 32'h1);
    chk("restart segments", 32'(segments), 32'h3F);
    frame_check("pending discarded", {7'h3F, 7'h3F, 7'h3F, 7'h3F}, 4'b0000);

    do_reset(2);
    repeat (800) begin
      load  = $urandom_range(0, 7) == 0;
      value = $urandom_range(0, 3) == 0 ? 16'($urandom_range(0, 255)) : 16'($urandom);
      dp_in = 4'($urandom);
      if ($urandom_range(0, 31) == 0) blank_lz = ~blank_lz;
      reset = $urandom_range(0, 199) == 0;
      step();
    end
    reset = 0;
    load  = 0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
